// File: rtl/prio_enc_pipe.sv
// prio_enc_pipe: pipelined priority encoder with a one-entry valid/ready
// output register (1-cycle latency, full throughput).
//
// Build option: define PRIO_ENC_RR_EN to replace the fixed highest-index-wins
// arbitration with a rotating (round-robin) search pointer. With the macro
// undefined the block is purely fixed-priority and carries no pointer state.
//
// code/none are forced to zero by reset so they are never X, even while
// out_vld is low.
module prio_enc_pipe #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         in_vld,
    output logic         in_rdy,
    output logic [W-1:0] code,
    output logic         none,
    output logic         out_vld,
    input  logic         out_rdy
);

    logic         accept;
    logic         win_any;
    logic [W-1:0] win_idx;

    // The output slot can take a new vector when empty or being drained now.
    always_comb begin
        in_rdy = !out_vld || out_rdy;
        accept = in_vld && in_rdy;
    end

`ifdef PRIO_ENC_RR_EN

    logic [W-1:0] ptr;

    // Walk downward from ptr, wrapping from 0 to N-1; the first set bit wins.
    always_comb begin : rr_search
        int           idx;
        logic [W-1:0] idx_w;
        win_any = 1'b0;
        win_idx = '0;
        idx     = 0;
        idx_w   = '0;
        for (int j = 0; j < N; j++) begin
            idx   = (int'(ptr) - j + N) % N;
            idx_w = W'(idx);
            if (!win_any && req[idx_w]) begin
                win_any = 1'b1;
                win_idx = idx_w;
            end
        end
    end

    // After a winner k, the search restarts just below k so k becomes last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= W'(N - 1);
        end else if (accept && win_any) begin
            ptr <= (win_idx == '0) ? W'(N - 1) : (win_idx - 1'b1);
        end
    end

`else

    // Fixed priority: scanning upward lets the highest set index win.
    always_comb begin : fixed_search
        win_any = 1'b0;
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                win_any = 1'b1;
                win_idx = W'(i);
            end
        end
    end

`endif

    // Output register: load on accept, empty on drain, otherwise hold steady.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            code    <= '0;
            none    <= 1'b0;
        end else if (accept) begin
            out_vld <= 1'b1;
            code    <= win_any ? win_idx : '0;
            none    <= !win_any;
        end else if (out_vld && out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prio_enc_pipe.sv
// tb_prio_enc_pipe: directed and random stimulus for prio_enc_pipe (N=8),
// compared cycle by cycle against a behavioural model of the arbitration rules.
// Define PRIO_ENC_RR_EN for both files to exercise the round-robin build.
module tb_prio_enc_pipe;

    localparam int N = 8;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic         in_vld = 1'b0;
    logic         in_rdy;
    logic [W-1:0] code;
    logic         none;
    logic         out_vld;
    logic         out_rdy = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    bit m_vld  = 1'b0;
    int m_code = 0;
    bit m_none = 1'b0;
    int m_ptr  = N - 1;

    prio_enc_pipe #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .code    (code),
        .none    (none),
        .out_vld (out_vld),
        .out_rdy (out_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winner by the arbitration rule: fixed = highest set index; round-robin =
    // first set bit visiting p, p-1, ..., 0, N-1, ..., p+1.
    function automatic void ref_win(input logic [N-1:0] r, input int p,
                                    output int k, output bit any);
        k   = 0;
        any = 1'b0;
`ifdef PRIO_ENC_RR_EN
        for (int j = 0; j < N; j++) begin
            int idx = (p - j + N) % N;
            if (!any && r[idx]) begin
                any = 1'b1;
                k   = idx;
            end
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (!any && r[i]) begin
                any = 1'b1;
                k   = i;
            end
        end
`endif
    endfunction

    task automatic do_reset(input string tag);
        rst_n  = 1'b0;
        in_vld = 1'($urandom_range(0, 1));
        req    = N'($urandom);
        out_rdy = 1'b0;
        @(posedge clk);
        m_vld  = 1'b0;
        m_code = 0;
        m_none = 1'b0;
        m_ptr  = N - 1;
        @(negedge clk);
        check({tag, ".rst_out_vld"}, 64'(out_vld), 64'(0));
        check({tag, ".rst_code"}, 64'(code), 64'(0));
        check({tag, ".rst_none"}, 64'(none), 64'(0));
        rst_n  = 1'b1;
        in_vld = 1'b0;
        #1;
        check({tag, ".rst_in_rdy"}, 64'(in_rdy), 64'(1));
    endtask

    // One clock of stimulus, starting just after a falling edge.
    task automatic step(input logic [N-1:0] r, input logic v, input logic ordy, input string tag);
        bit acc;
        bit any;
        int k;
        req     = r;
        in_vld  = v;
        out_rdy = ordy;
        #1;
        check({tag, ".in_rdy"}, 64'(in_rdy), 64'(!m_vld || ordy));
        @(posedge clk);
        acc = v && (!m_vld || ordy);
        if (acc) begin
            ref_win(r, m_ptr, k, any);
            m_vld  = 1'b1;
            m_code = any ? k : 0;
            m_none = !any;
            if (any) m_ptr = (k + N - 1) % N;
        end else if (ordy) begin
            m_vld = 1'b0;
        end
        @(negedge clk);
        check({tag, ".out_vld"}, 64'(out_vld), 64'(m_vld));
        if (m_vld) begin
            check({tag, ".code"}, 64'(code), 64'(m_code));
            check({tag, ".none"}, 64'(none), 64'(m_none));
        end
    endtask

    initial begin
        logic [N-1:0] r;
        @(negedge clk);
        do_reset("init");

        // fixed example, and zero vector
        step(8'b0010_0110, 1'b1, 1'b1, "fix");
        check("fix.code5", 64'(code), 64'(5));
        check("fix.none0", 64'(none), 64'(0));
        step(8'h00, 1'b1, 1'b1, "zero");
        check("zero.code0", 64'(code), 64'(0));
        check("zero.none1", 64'(none), 64'(1));
        check("zero.vld", 64'(out_vld), 64'(1));

        // back-to-back with no bubble
        step(8'h80, 1'b1, 1'b1, "b2b0");
        check("b2b.code7", 64'(code), 64'(7));
        step(8'h01, 1'b1, 1'b1, "b2b1");
        check("b2b.code0", 64'(code), 64'(0));
        step(8'h10, 1'b1, 1'b1, "b2b2");
        check("b2b.code4", 64'(code), 64'(4));
        step(8'h00, 1'b0, 1'b1, "drain");

        // stall: code 3 held for 4 cycles while a new vector waits
        step(8'h08, 1'b1, 1'b1, "stall_ld");
        for (int i = 0; i < 4; i++) begin
            step(8'h40, 1'b1, 1'b0, "stall");
            check("stall.code3", 64'(code), 64'(3));
            check("stall.in_rdy0", 64'(in_rdy), 64'(0));
        end
        step(8'h40, 1'b1, 1'b1, "stall_rel");
        check("stall_rel.code6", 64'(code), 64'(6));

        // reset while a stalled result is pending
        step(8'h0C, 1'b1, 1'b0, "pre_rst");
        step(8'h0C, 1'b1, 1'b0, "pre_rst_hold");
        do_reset("midrst");
        step(8'h00, 1'b0, 1'b0, "post_rst_idle");
        check("post_rst.vld0", 64'(out_vld), 64'(0));

`ifdef PRIO_ENC_RR_EN
        begin
            int seq_ff[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
            int seq_81[3] = '{7, 0, 7};
            do_reset("rr_ff");
            for (int i = 0; i < 9; i++) begin
                step(8'hFF, 1'b1, 1'b1, "rr_ff");
                check("rr_ff.seq", 64'(code), 64'(seq_ff[i]));
            end
            do_reset("rr_81");
            for (int i = 0; i < 3; i++) begin
                step(8'h81, 1'b1, 1'b1, "rr_81");
                check("rr_81.seq", 64'(code), 64'(seq_81[i]));
            end
        end
`endif

        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       r = '0;
                1:       r = N'(1) << $urandom_range(0, N - 1);
                default: r = N'($urandom);
            endcase
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rnd_rst");
            end else begin
                step(r, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6), "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/prio_enc_pipe.md
PRIO_ENC_PIPE -- requirements
Module: prio_enc_pipe

Interface
REQ-001 Parameter N, default 8: request vector width; legal range 2..64.
REQ-002 Localparam W = $clog2(N): code width, derived and not overridable.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst_n  input  1: synchronous, active-low reset.
REQ-005 req  input  N: request vector; bit i set means source i is requesting.
REQ-006 in_vld  input  1: req is valid this cycle.
REQ-007 in_rdy  output  1: block accepts req this cycle.
REQ-008 code  output  W: encoded index of the winning request bit.
REQ-009 none  output  1: accepted vector had no bits set.
REQ-010 out_vld  output  1: code/none hold a result.
REQ-011 out_rdy  input  1: consumer takes the result this cycle.

Function
REQ-012 Accept occurs on a cycle with in_vld=1 and in_rdy=1; the result is registered and out_vld=1 on the next cycle, giving 1-cycle latency.
REQ-013 in_rdy = !out_vld || out_rdy, combinationally, so a full-throughput stream needs no bubble.
REQ-014 Output register load: on accept, load the new result; else if out_vld && out_rdy, clear out_vld; else hold.
REQ-015 While out_vld=1 and out_rdy=0, code and none shall stay bit-stable.
REQ-016 Fixed-priority mode: the highest set index wins (bit N-1 highest, bit 0 lowest).
REQ-017 If req is all-zero on accept, the block shall set code=0 and none=1, and out_vld shall still assert.
REQ-018 If req is non-zero on accept, none=0.
REQ-019 Accept and drain in the same cycle (full output, out_rdy=1, in_vld=1) shall replace the result with no gap; out_vld stays 1.
REQ-020 code and none values while out_vld=0 are don't-care to the consumer but shall not be X after reset.
REQ-021 No state other than the output register and the priority pointer (REQ-026) shall exist.

Reset
REQ-022 While rst_n=0 at a rising edge: out_vld=0, code=0, none=0.
REQ-023 A reset mid-operation discards any pending result; no result shall appear after reset release unless a new accept occurs.
REQ-024 in_rdy=1 on the first cycle after reset release.

Configuration
REQ-025 Macro PRIO_ENC_RR_EN selects the round-robin feature; when it is undefined, the block is purely fixed-priority per REQ-016.
REQ-026 With PRIO_ENC_RR_EN: a pointer ptr[W-1:0] resets to N-1; the search order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1, and the first set bit wins.
REQ-027 With PRIO_ENC_RR_EN: on an accept with winner k, ptr shall become (k-1) mod N, so k becomes lowest priority; on an all-zero accept or no accept, ptr holds.
REQ-028 With PRIO_ENC_RR_EN and only one bit set, that bit wins regardless of ptr.
REQ-029 Without PRIO_ENC_RR_EN, no ptr register shall be synthesised.

Verification (N=8)
REQ-030 Fixed: req=8'b0010_0110, in_vld=1, out_rdy=1 -> next cycle code=5, none=0, out_vld=1.
REQ-031 Zero: req=8'h00 accepted -> code=0, none=1, out_vld=1.
REQ-032 Stall: result code=3 with out_rdy=0 for 4 cycles, in_vld=1 -> in_rdy=0, code stays 3; on out_rdy=1 the next vector loads the following cycle.
REQ-033 Back-to-back: req=80h, 01h, 10h on consecutive cycles, out_rdy=1 -> code=7, 0, 4 on consecutive cycles with no bubble.
REQ-034 RR (PRIO_ENC_RR_EN): req=8'hFF held for 9 accepts -> code sequence 7,6,5,4,3,2,1,0,7; req=8'h81 after reset -> 7 then 0 then 7.
REQ-035 Reset: assert rst_n=0 while out_vld=1 and out_rdy=0 -> next cycle out_vld=0 and code=0; RR ptr returns to 7.
